// File: rtl/snake_pkg.sv
// Shared snake game definitions: direction encoding, reversal rule and
// the apple-placement LFSR constants used by the input stage and game core.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_dir_input_debounce.sv
// One arrow button: two-flop synchroniser, polarity normalisation,
// run-length debouncer and a registered released-to-pressed pulse.
module button_debounce #(
  parameter int   DEBOUNCE_CYCLES = 200_000,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          stable;
  logic [CW-1:0] cnt;

  assign level = sync[1] ^ ACTIVE_LOW;

  // sync flops reset to the raw value that reads as released
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= {2{ACTIVE_LOW}};
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= level;
        cnt    <= '0;
        rise   <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Arrow-button conditioner feeding the snake core one direction per step.
// Define SNAKE_TURN_QUEUE_EN for a 2-entry turn FIFO; else latest-wins slot.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 200_000,
  parameter logic [3:0] ACTIVE_LOW_MASK = 4'b0011,
  parameter logic [1:0] INIT_DIR        = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arrow_up,
  input  logic        arrow_down,
  input  logic        arrow_left,
  input  logic        arrow_right,
  input  logic        step,
  output logic [1:0]  dir_out,
  output logic        press,
  output logic [15:0] seed_out
);

  logic [3:0]  raw_btn;
  logic [3:0]  rise;
  logic        edge_any;
  logic [1:0]  edge_dir;
  logic [1:0]  cur_dir;
  logic [1:0]  cur_next;
  logic [1:0]  ref_dir;
  logic        room;
  logic        accept;
  logic        has_head;
  logic [1:0]  head;
  logic [15:0] lfsr;

  assign raw_btn = {arrow_right, arrow_left, arrow_down, arrow_up};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[b])
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_btn[b]),
      .rise  (rise[b])
    );
  end

  always_comb begin
    edge_any = 1'b1;
    edge_dir = DIR_UP;
    priority case (1'b1)
      rise[0]: edge_dir = DIR_UP;
      rise[1]: edge_dir = DIR_DOWN;
      rise[2]: edge_dir = DIR_LEFT;
      rise[3]: edge_dir = DIR_RIGHT;
      default: edge_any = 1'b0;
    endcase
  end

  assign cur_next = step ? dir_out : cur_dir;

`ifdef SNAKE_TURN_QUEUE_EN
  logic [1:0] q0;
  logic [1:0] q1;
  logic [1:0] qcnt;
  logic [1:0] pop_cnt;
  logic [1:0] pop_head;

  // pop happens before the incoming edge is judged
  always_comb begin
    pop_cnt  = qcnt;
    pop_head = q0;
    if (step && qcnt != 2'd0) begin
      pop_cnt  = qcnt - 2'd1;
      pop_head = q1;
    end
    ref_dir = cur_next;
    if (pop_cnt == 2'd2)
      ref_dir = q1;
    else if (pop_cnt == 2'd1)
      ref_dir = pop_head;
    room = (pop_cnt != 2'd2);
  end

  assign has_head = (qcnt != 2'd0);
  assign head     = q0;

  always_ff @(posedge clk) begin
    if (reset) begin
      q0   <= INIT_DIR;
      q1   <= INIT_DIR;
      qcnt <= 2'd0;
    end else begin
      qcnt <= pop_cnt + {1'b0, accept};
      q0   <= pop_head;
      if (accept) begin
        if (pop_cnt == 2'd0)
          q0 <= edge_dir;
        else
          q1 <= edge_dir;
      end
    end
  end
`else
  logic       slot_v;
  logic [1:0] slot_d;

  assign ref_dir  = cur_next;
  assign room     = 1'b1;
  assign has_head = slot_v;
  assign head     = slot_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v <= 1'b0;
      slot_d <= INIT_DIR;
    end else if (accept) begin
      slot_v <= 1'b1;
      slot_d <= edge_dir;
    end else if (step) begin
      slot_v <= 1'b0;
    end
  end
`endif

  assign accept = edge_any && room &&
                  (edge_dir != ref_dir) &&
                  (edge_dir != dir_reverse(ref_dir));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_dir  <= INIT_DIR;
      dir_out  <= INIT_DIR;
      press    <= 1'b0;
      lfsr     <= LFSR_SEED;
      seed_out <= LFSR_SEED;
    end else begin
      cur_dir <= cur_next;
      dir_out <= has_head ? head : cur_dir;
      press   <= accept;
      lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      if (accept)
        seed_out <= seed_out ^ lfsr;
    end
  end

endmodule
